// File: rtl/psimd_pkg.sv
// Shared definitions for the PSIMD vector register file and scoreboard.
// Defaults, address type and the pair-address validity helper.
package psimd_pkg;

    localparam int XLEN_D  = 64;
    localparam int DEPTH_D = 32;
    localparam int AW_D    = $clog2(DEPTH_D);

    typedef logic [AW_D-1:0] reg_addr_t;

    // A pair (rd, rd+1) is legal only when rd+1 stays inside the file.
    function automatic logic pair_ok(
        input int unsigned addr,
        input int unsigned depth
    );
        return (addr + 1) < depth;
    endfunction

endpackage

// File: rtl/psimd_scoreboard.sv
// Pending-write scoreboard: busy vector, issue hazard check,
// registered pending count and sticky protocol-error flag.
module psimd_scoreboard
    import psimd_pkg::*;
#(
    parameter int DEPTH = DEPTH_D,
    parameter int AW    = $clog2(DEPTH),
    parameter int NRD   = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic [NRD-1:0]  rd_en,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic            iss_pair,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic            wb_pair,
    output logic            iss_ready,
    output logic [DEPTH-1:0] busy,
    output logic [AW:0]     pend_cnt,
    output logic            err
);

    logic [DEPTH-1:0] r_busy;
    logic [AW:0]      r_pend;
    logic             r_err;

    logic             w_wb_hi_ok;
    logic             w_iss_hi_ok;
    logic [AW-1:0]    w_wb_rd1;
    logic [AW-1:0]    w_iss_rd1;
    logic [DEPTH-1:0] w_clr;
    logic [DEPTH-1:0] w_set;
    logic [DEPTH-1:0] w_eff;
    logic [DEPTH-1:0] w_next;
    logic [AW:0]      w_cnt;
    logic             w_hazard;
    logic             w_err_evt;

    assign w_wb_hi_ok  = pair_ok(32'(wb_rd), DEPTH);
    assign w_iss_hi_ok = pair_ok(32'(iss_rd), DEPTH);
    assign w_wb_rd1    = wb_rd + AW'(1);
    assign w_iss_rd1   = iss_rd + AW'(1);

    always_comb begin
        w_clr = '0;
        if (wb_valid) begin
            w_clr[wb_rd] = 1'b1;
            if (wb_pair && w_wb_hi_ok) begin
                w_clr[w_wb_rd1] = 1'b1;
            end
        end
    end

    // Bits released by this cycle's writeback no longer block issue.
    assign w_eff = r_busy & ~w_clr;

    always_comb begin
        w_hazard = w_eff[iss_rd];
        if (iss_pair) begin
            if (!w_iss_hi_ok) begin
                w_hazard = 1'b1;
            end else if (w_eff[w_iss_rd1]) begin
                w_hazard = 1'b1;
            end
        end
        for (int k = 0; k < NRD; k++) begin
            if (rd_en[k] && w_eff[rd_addr[k*AW +: AW]]) begin
                w_hazard = 1'b1;
            end
        end
    end

    assign iss_ready = !w_hazard;

    always_comb begin
        w_set = '0;
        if (iss_valid && iss_ready) begin
            w_set[iss_rd] = 1'b1;
            if (iss_pair) begin
                w_set[w_iss_rd1] = 1'b1;
            end
        end
    end

    assign w_next = w_eff | w_set;

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt = w_cnt + (AW+1)'(w_next[i]);
        end
    end

    always_comb begin
        w_err_evt = 1'b0;
        if (wb_valid) begin
            if (!r_busy[wb_rd]) begin
                w_err_evt = 1'b1;
            end
            if (wb_pair) begin
                if (!w_wb_hi_ok) begin
                    w_err_evt = 1'b1;
                end else if (!r_busy[w_wb_rd1]) begin
                    w_err_evt = 1'b1;
                end
            end
        end
        if (iss_valid && iss_pair && !w_iss_hi_ok) begin
            w_err_evt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_pend <= '0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= w_next;
            r_pend <= w_cnt;
            r_err  <= r_err | w_err_evt;
        end
    end

    assign busy     = r_busy;
    assign pend_cnt = r_pend;
    assign err      = r_err;

endmodule

// File: rtl/psimd_vreg_file_sb.sv
// PSIMD vector register file with paired writeback, same-cycle
// bypass and an integrated issue scoreboard.
module psimd_vreg_file_sb
    import psimd_pkg::*;
#(
    parameter int XLEN   = XLEN_D,
    parameter int DEPTH  = DEPTH_D,
    parameter int AW     = $clog2(DEPTH),
    parameter int NRD    = 3,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic [NRD-1:0]    rd_en,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    input  logic              iss_pair,
    output logic              iss_ready,
    input  logic              wb_valid,
    input  logic [AW-1:0]     wb_rd,
    input  logic              wb_pair,
    input  logic [XLEN-1:0]   wb_lo,
    input  logic [XLEN-1:0]   wb_hi,
    output logic [DEPTH-1:0]  busy,
    output logic [AW:0]       pend_cnt,
    output logic              err
);

    logic [XLEN-1:0] r_regs [DEPTH];

    logic            w_hi_ok;
    logic [AW-1:0]   w_rd1;
    logic [AW-1:0]   w_ra;
    logic [XLEN-1:0] w_rdat;

    assign w_hi_ok = pair_ok(32'(wb_rd), DEPTH);
    assign w_rd1   = wb_rd + AW'(1);

    // High half at the last register is dropped; no wrap to r0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_valid) begin
            r_regs[wb_rd] <= wb_lo;
            if (wb_pair && w_hi_ok) begin
                r_regs[w_rd1] <= wb_hi;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        w_ra    = '0;
        w_rdat  = '0;
        for (int k = 0; k < NRD; k++) begin
            w_ra   = rd_addr[k*AW +: AW];
            w_rdat = r_regs[w_ra];
            if (BYPASS != 0 && wb_valid) begin
                if (w_ra == wb_rd) begin
                    w_rdat = wb_lo;
                end else if (wb_pair && w_hi_ok && w_ra == w_rd1) begin
                    w_rdat = wb_hi;
                end
            end
            rd_data[k*XLEN +: XLEN] = w_rdat;
        end
    end

    psimd_scoreboard #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .NRD   (NRD)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr   (rd_addr),
        .rd_en     (rd_en),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_pair  (iss_pair),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_pair   (wb_pair),
        .iss_ready (iss_ready),
        .busy      (busy),
        .pend_cnt  (pend_cnt),
        .err       (err)
    );

endmodule

// File: tb/tb_psimd_vreg_file_sb.sv
// Bench for psimd_vreg_file_sb: array model for the default build,
// directed checks for a narrow no-bypass build.
module tb_psimd_vreg_file_sb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // default build: XLEN=64 DEPTH=32 NRD=3 BYPASS=1
    logic [14:0]  a_rd_addr;
    logic [2:0]   a_rd_en;
    logic [191:0] a_rd_data;
    logic         a_iss_valid, a_iss_pair, a_iss_ready;
    logic [4:0]   a_iss_rd;
    logic         a_wb_valid, a_wb_pair;
    logic [4:0]   a_wb_rd;
    logic [63:0]  a_wb_lo, a_wb_hi;
    logic [31:0]  a_busy;
    logic [5:0]   a_pend;
    logic         a_err;

    // sweep build: XLEN=32 DEPTH=16 NRD=4 BYPASS=0
    logic [15:0]  b_rd_addr;
    logic [3:0]   b_rd_en;
    logic [127:0] b_rd_data;
    logic         b_iss_valid, b_iss_pair, b_iss_ready;
    logic [3:0]   b_iss_rd;
    logic         b_wb_valid, b_wb_pair;
    logic [3:0]   b_wb_rd;
    logic [31:0]  b_wb_lo, b_wb_hi;
    logic [15:0]  b_busy;
    logic [4:0]   b_pend;
    logic         b_err;

    psimd_vreg_file_sb dut_a (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(a_rd_addr), .rd_en(a_rd_en), .rd_data(a_rd_data),
        .iss_valid(a_iss_valid), .iss_rd(a_iss_rd),
        .iss_pair(a_iss_pair), .iss_ready(a_iss_ready),
        .wb_valid(a_wb_valid), .wb_rd(a_wb_rd), .wb_pair(a_wb_pair),
        .wb_lo(a_wb_lo), .wb_hi(a_wb_hi),
        .busy(a_busy), .pend_cnt(a_pend), .err(a_err)
    );

    psimd_vreg_file_sb #(
        .XLEN(32), .DEPTH(16), .NRD(4), .BYPASS(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(b_rd_addr), .rd_en(b_rd_en), .rd_data(b_rd_data),
        .iss_valid(b_iss_valid), .iss_rd(b_iss_rd),
        .iss_pair(b_iss_pair), .iss_ready(b_iss_ready),
        .wb_valid(b_wb_valid), .wb_rd(b_wb_rd), .wb_pair(b_wb_pair),
        .wb_lo(b_wb_lo), .wb_hi(b_wb_hi),
        .busy(b_busy), .pend_cnt(b_pend), .err(b_err)
    );

    task automatic check(input string name,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model of build A ----------------
    bit [63:0] m_reg [32];
    bit        m_busy [32];
    bit        m_err;

    function automatic bit released(input int r);
        if (!a_wb_valid) return 1'b0;
        if (r == int'(a_wb_rd)) return 1'b1;
        return a_wb_pair && a_wb_rd != 31 && r == int'(a_wb_rd) + 1;
    endfunction

    function automatic bit eff(input int r);
        return m_busy[r] && !released(r);
    endfunction

    function automatic bit exp_ready();
        bit stall = eff(int'(a_iss_rd));
        if (a_iss_pair) begin
            if (a_iss_rd == 31) stall = 1'b1;
            else if (eff(int'(a_iss_rd) + 1)) stall = 1'b1;
        end
        for (int k = 0; k < 3; k++)
            if (a_rd_en[k] && eff(int'(a_rd_addr[k*5 +: 5])))
                stall = 1'b1;
        return !stall;
    endfunction

    function automatic logic [63:0] exp_read(input int a);
        if (a_wb_valid && a == int'(a_wb_rd)) return a_wb_lo;
        if (a_wb_valid && a_wb_pair && a_wb_rd != 31 &&
            a == int'(a_wb_rd) + 1) return a_wb_hi;
        return m_reg[a];
    endfunction

    function automatic logic [31:0] m_busy_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    always @(negedge rst_n) begin
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_err = 1'b0;
    end

    always @(posedge clk) begin
        bit rdy;
        int rd;
        if (rst_n) begin
            rdy = exp_ready();
            rd  = int'(a_wb_rd);
            if (a_wb_valid) begin
                if (!m_busy[rd]) m_err = 1'b1;
                if (a_wb_pair) begin
                    if (rd == 31) m_err = 1'b1;
                    else if (!m_busy[rd+1]) m_err = 1'b1;
                end
            end
            if (a_iss_valid && a_iss_pair && a_iss_rd == 31) m_err = 1'b1;
            if (a_wb_valid) begin
                m_busy[rd] = 1'b0;
                m_reg[rd]  = a_wb_lo;
                if (a_wb_pair && rd != 31) begin
                    m_busy[rd+1] = 1'b0;
                    m_reg[rd+1]  = a_wb_hi;
                end
            end
            if (a_iss_valid && rdy) begin
                m_busy[a_iss_rd] = 1'b1;
                if (a_iss_pair) m_busy[int'(a_iss_rd)+1] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++)
            check("model rd_data", a_rd_data[k*64 +: 64],
                  exp_read(int'(a_rd_addr[k*5 +: 5])));
        check("model iss_ready", 64'(a_iss_ready), 64'(exp_ready()));
        check("model busy", 64'(a_busy), 64'(m_busy_vec()));
        check("model pend_cnt", 64'(a_pend), 64'(m_count()));
        check("model err", 64'(a_err), 64'(m_err));
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        a_rd_addr = '0; a_rd_en = '0;
        a_iss_valid = 0; a_iss_rd = '0; a_iss_pair = 0;
        a_wb_valid = 0; a_wb_rd = '0; a_wb_pair = 0;
        a_wb_lo = '0; a_wb_hi = '0;
        b_rd_addr = '0; b_rd_en = '0;
        b_iss_valid = 0; b_iss_rd = '0; b_iss_pair = 0;
        b_wb_valid = 0; b_wb_rd = '0; b_wb_pair = 0;
        b_wb_lo = '0; b_wb_hi = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        #2;
        check("reset busy", 64'(a_busy), 64'h0);
        check("reset pend_cnt", 64'(a_pend), 64'h0);
        check("reset err", 64'(a_err), 64'h0);
        #10 rst_n = 1'b1;
        #1;

        // 1: writeback to a non-busy register
        a_wb_valid = 1; a_wb_rd = 5;
        a_wb_lo = 64'hDEAD_BEEF_0000_0001;
        step();
        idle(); a_rd_addr[4:0] = 5;
        #1;
        check("t1 read r5", a_rd_data[63:0], 64'hDEAD_BEEF_0000_0001);
        check("t1 err", 64'(a_err), 64'h1);

        // 2: pair issue, RAW stall released by same-cycle writeback
        do_reset();
        a_iss_valid = 1; a_iss_rd = 8; a_iss_pair = 1;
        #1 check("t2 issue ready", 64'(a_iss_ready), 64'h1);
        step();
        idle();
        #1;
        check("t2 busy", 64'(a_busy), 64'h300);
        check("t2 pend_cnt", 64'(a_pend), 64'd2);
        a_iss_valid = 1; a_iss_rd = 12; a_rd_en = 3'b001;
        a_rd_addr[4:0] = 9;
        #1 check("t2 raw stall", 64'(a_iss_ready), 64'h0);
        a_wb_valid = 1; a_wb_rd = 8; a_wb_pair = 1;
        a_wb_lo = 64'h11; a_wb_hi = 64'h22;
        #1;
        check("t2 released", 64'(a_iss_ready), 64'h1);
        check("t2 bypass r9", a_rd_data[63:0], 64'h22);
        step();
        idle(); a_rd_addr[4:0] = 8;
        #1;
        check("t2 read r8", a_rd_data[63:0], 64'h11);
        check("t2 busy after", 64'(a_busy), 64'h1000);
        check("t2 err", 64'(a_err), 64'h0);

        // 3: pair at the last register
        do_reset();
        a_iss_valid = 1; a_iss_rd = 31; a_iss_pair = 1;
        #1 check("t3 pair31 ready", 64'(a_iss_ready), 64'h0);
        step();
        idle();
        #1;
        check("t3 err", 64'(a_err), 64'h1);
        check("t3 busy", 64'(a_busy), 64'h0);
        a_wb_valid = 1; a_wb_rd = 31; a_wb_pair = 1;
        a_wb_lo = 64'hAAAA; a_wb_hi = 64'hBBBB;
        step();
        idle(); a_rd_addr = {5'd0, 5'd0, 5'd31};
        #1;
        check("t3 r31", a_rd_data[63:0], 64'hAAAA);
        check("t3 r0", a_rd_data[127:64], 64'h0);

        // 4: disabled read port and WAW
        do_reset();
        a_iss_valid = 1; a_iss_rd = 3;
        step();
        idle(); a_rd_addr[4:0] = 3;
        a_iss_valid = 1; a_iss_rd = 4;
        #1 check("t4 rd_en off", 64'(a_iss_ready), 64'h1);
        a_iss_rd = 3;
        #1 check("t4 waw", 64'(a_iss_ready), 64'h0);
        step();
        check("t4 waw held", 64'(a_iss_ready), 64'h0);
        a_wb_valid = 1; a_wb_rd = 3; a_wb_lo = 64'h33;
        #1 check("t4 waw released", 64'(a_iss_ready), 64'h1);
        step();
        idle();
        #1;
        check("t4 busy set wins", 64'(a_busy), 64'h8);
        check("t4 pend_cnt", 64'(a_pend), 64'd1);
        check("t4 err", 64'(a_err), 64'h0);

        // 5: fill every register, then asynchronous reset
        do_reset();
        a_wb_valid = 1; a_wb_rd = 5; a_wb_lo = 64'h55;
        step();
        for (int r = 0; r < 16; r++) begin
            idle();
            a_iss_valid = 1; a_iss_pair = 1; a_iss_rd = 5'(2*r);
            step();
        end
        idle();
        #1;
        check("t5 full pend_cnt", 64'(a_pend), 64'd32);
        check("t5 full busy", 64'(a_busy), 64'hFFFF_FFFF);
        a_rd_addr[4:0] = 5;
        #1 check("t5 r5 before", a_rd_data[63:0], 64'h55);
        rst_n = 1'b0;
        #1;
        check("t5 async busy", 64'(a_busy), 64'h0);
        check("t5 async pend", 64'(a_pend), 64'h0);
        check("t5 async err", 64'(a_err), 64'h0);
        check("t5 async r5", a_rd_data[63:0], 64'h0);
        rst_n = 1'b1;

        // 6: narrow build without bypass
        step();
        b_wb_valid = 1; b_wb_rd = 7; b_wb_lo = 32'h1234;
        b_rd_addr[11:8] = 7;
        #1 check("t6 no bypass", 64'(b_rd_data[95:64]), 64'h0);
        step();
        b_wb_lo = 32'h5678;
        #1 check("t6 old value", 64'(b_rd_data[95:64]), 64'h1234);
        step();
        idle(); b_rd_addr[11:8] = 7;
        #1 check("t6 new value", 64'(b_rd_data[95:64]), 64'h5678);
        b_wb_valid = 1; b_wb_rd = 15; b_wb_pair = 1;
        b_wb_lo = 32'hA5; b_wb_hi = 32'h5A;
        step();
        idle(); b_rd_addr = {4'd0, 4'd0, 4'd0, 4'd15};
        #1;
        check("t6 r15", 64'(b_rd_data[31:0]), 64'hA5);
        check("t6 r0", 64'(b_rd_data[63:32]), 64'h0);
        check("t6 err", 64'(b_err), 64'h1);
        b_iss_valid = 1; b_iss_rd = 14; b_iss_pair = 1;
        #1 check("t6 pair14 ready", 64'(b_iss_ready), 64'h1);
        step();
        idle();
        #1;
        check("t6 busy", 64'(b_busy), 64'hC000);
        check("t6 pend_cnt", 64'(b_pend), 64'd2);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
